// File: rtl/exe_stage.sv
// MIPS execute stage: registers the decode bus, computes the ALU result, issues the data-SRAM request, feeds bypass info to decode.
// Single-cycle (result valid in the cycle after acceptance); holds its register and outputs while ms_allowin is low.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 137,
  parameter int ES_TO_MS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       es_load_op,
  output logic [31:0]                es_to_ds_result,
  output logic [4:0]                 ES_dest,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  typedef struct packed {
    logic        src2_is_zero;
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_bus_t;

  ds_bus_t     ds_bus;
  ds_bus_t     es_bus;
  logic        es_valid;
  logic        es_ready_go;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  sa;
  logic [31:0] add_sub_res;
  logic [31:0] sra_res;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] alu_result;

  assign ds_bus      = ds_to_es_bus;
  assign es_ready_go = 1'b1;
  assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_bus <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      es_bus <= ds_bus;
    end
  end

  // Operand muxes: shift amount from imm[10:6], immediate either zero- or sign-extended.
  assign src1 = es_bus.src1_is_sa ? {27'b0, es_bus.imm[10:6]} :
                es_bus.src1_is_pc ? es_bus.pc : es_bus.rs_value;
  assign src2 = es_bus.src2_is_imm ?
                  (es_bus.src2_is_zero ? {16'b0, es_bus.imm} : {{16{es_bus.imm[15]}}, es_bus.imm}) :
                es_bus.src2_is_8 ? 32'd8 : es_bus.rt_value;
  assign sa   = src1[4:0];

  assign add_sub_res = es_bus.alu_op[1] ? (src1 - src2) : (src1 + src2);
  assign slt_res     = $signed(src1) < $signed(src2);
  assign sltu_res    = src1 < src2;
  assign sra_res     = 32'($signed(src2) >>> sa);

  // One-hot select: an all-zero alu_op yields zero.
  always_comb begin
    alu_result = 32'b0;
    alu_result |= {32{es_bus.alu_op[0] | es_bus.alu_op[1]}} & add_sub_res;
    alu_result |= {32{es_bus.alu_op[2]}}  & {31'b0, slt_res};
    alu_result |= {32{es_bus.alu_op[3]}}  & {31'b0, sltu_res};
    alu_result |= {32{es_bus.alu_op[4]}}  & (src1 & src2);
    alu_result |= {32{es_bus.alu_op[5]}}  & ~(src1 | src2);
    alu_result |= {32{es_bus.alu_op[6]}}  & (src1 | src2);
    alu_result |= {32{es_bus.alu_op[7]}}  & (src1 ^ src2);
    alu_result |= {32{es_bus.alu_op[8]}}  & (src2 << sa);
    alu_result |= {32{es_bus.alu_op[9]}}  & (src2 >> sa);
    alu_result |= {32{es_bus.alu_op[10]}} & sra_res;
    alu_result |= {32{es_bus.alu_op[11]}} & {src2[15:0], 16'b0};
  end

  // Requests repeat while stalled; loads and word stores tolerate that.
  assign data_sram_en    = es_valid && (es_bus.load_op || es_bus.mem_we);
  assign data_sram_wen   = {4{es_valid && es_bus.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus.rt_value;

  assign es_to_ds_result = alu_result;
  assign ES_dest         = (es_valid && es_bus.gr_we) ? es_bus.dest : 5'd0;
  assign es_load_op      = es_valid && es_bus.load_op;

  assign es_to_ms_bus = {es_bus.load_op, es_bus.gr_we, es_bus.dest, alu_result, es_bus.pc};

endmodule
